mux_key_reg: RTL and testbench



---
 rtl/mux_key_reg.sv | 82 ++++++++
 tb/tb_mux_key_reg.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mux_key_reg.sv
// mux_key_reg: keyed lookup multiplexer with a registered output stage.
//
// The table `lut` packs NR_KEY {key, data} pairs. Entry 0 sits at the MSB end
// and entry NR_KEY-1 ends at bit 0. `out`/`hit` are a pure combinational
// lookup of `key`. When several entries carry the same key, the lowest index
// wins. `q` is a write-enabled register of `out` with synchronous
// active-high reset.
//
// Build option: define MUX_KEY_REG_DEFAULT_EN to add the `default_out` port.
// On a miss, `out` then equals `default_out`. Without the macro, a miss
// drives `out` to zero. `hit` is the same in both builds.
module mux_key_reg #(
    parameter int                     NR_KEY    = 2,
    parameter int                     KEY_LEN   = 1,
    parameter int                     DATA_LEN  = 1,
    parameter logic [DATA_LEN-1:0]    RESET_VAL = '0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [KEY_LEN-1:0]                     key,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]   lut,
    input  logic                                   wen,
`ifdef MUX_KEY_REG_DEFAULT_EN
    input  logic [DATA_LEN-1:0]                    default_out,
`endif
    output logic [DATA_LEN-1:0]                    out,
    output logic                                   hit,
    output logic [DATA_LEN-1:0]                    q
);

    localparam int ENTRY_W = KEY_LEN + DATA_LEN;
    localparam int TABLE_W = NR_KEY * ENTRY_W;

    // Unpacked view of the table. Entry g starts ENTRY_W*g bits below the MSB.
    logic [KEY_LEN-1:0]  key_tab  [NR_KEY];
    logic [DATA_LEN-1:0] data_tab [NR_KEY];

    for (genvar g = 0; g < NR_KEY; g++) begin : g_unpack
        assign key_tab[g]  = lut[TABLE_W - 1 - g*ENTRY_W -: KEY_LEN];
        assign data_tab[g] = lut[TABLE_W - 1 - g*ENTRY_W - KEY_LEN -: DATA_LEN];
    end

    // Value presented on a miss.
    logic [DATA_LEN-1:0] miss_val;
`ifdef MUX_KEY_REG_DEFAULT_EN
    assign miss_val = default_out;
`else
    assign miss_val = '0;
`endif

    logic [DATA_LEN-1:0] out_d;
    logic                hit_d;
    logic [DATA_LEN-1:0] q_q;

    // Lookup: scan from the highest index down so the lowest matching index
    // is the last to write. That entry wins on duplicate keys.
    always_comb begin
        hit_d = 1'b0;
        out_d = miss_val;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (key_tab[i] == key) begin
                hit_d = 1'b1;
                out_d = data_tab[i];
            end
        end
    end

    // Output register: reset has priority over load. With neither asserted,
    // the register holds its value.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RESET_VAL;
        end else if (wen) begin
            q_q <= out_d;
        end
    end

    assign out = out_d;
    assign hit = hit_d;
    assign q   = q_q;

endmodule

// File: tb/tb_mux_key_reg.sv
// Bench for mux_key_reg. It drives three instances from one clock:
//   u_dec : 32-entry 5-to-32 one-hot decoder
//   u_a   : 2-entry table {1:AA, 2:55}, RESET_VAL 8'h7E (also used for register tests)
//   u_dup : 2-entry table with duplicate keys {4:11, 4:22}
module tb_mux_key_reg;

    localparam int DEC_W = 32 * (5 + 32);

`ifdef MUX_KEY_REG_DEFAULT_EN
    localparam logic [7:0] MISS8 = 8'h3C;
`else
    localparam logic [7:0] MISS8 = 8'h00;
`endif

    logic clk;
    logic rst;
    logic wen;

    logic [4:0]        dec_key;
    logic [DEC_W-1:0]  dec_lut;
    logic [31:0]       dec_out;
    logic              dec_hit;
    logic [31:0]       dec_q;
    logic [31:0]       dec_dflt;

    logic [2:0]  a_key;
    logic [21:0] a_lut;
    logic [7:0]  a_out;
    logic        a_hit;
    logic [7:0]  a_q;

    logic [2:0]  dup_key;
    logic [21:0] dup_lut;
    logic [7:0]  dup_out;
    logic        dup_hit;
    logic [7:0]  dup_q;

    logic [7:0]  dflt;

    int n_vec = 0;
    int n_bad = 0;

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux_key_reg #(.NR_KEY(32), .KEY_LEN(5), .DATA_LEN(32), .RESET_VAL(32'h0)) u_dec (
        .clk(clk), .rst(rst), .key(dec_key), .lut(dec_lut), .wen(wen),
`ifdef MUX_KEY_REG_DEFAULT_EN
        .default_out(dec_dflt),
`endif
        .out(dec_out), .hit(dec_hit), .q(dec_q)
    );

    mux_key_reg #(.NR_KEY(2), .KEY_LEN(3), .DATA_LEN(8), .RESET_VAL(8'h7E)) u_a (
        .clk(clk), .rst(rst), .key(a_key), .lut(a_lut), .wen(wen),
`ifdef MUX_KEY_REG_DEFAULT_EN
        .default_out(dflt),
`endif
        .out(a_out), .hit(a_hit), .q(a_q)
    );

    mux_key_reg #(.NR_KEY(2), .KEY_LEN(3), .DATA_LEN(8), .RESET_VAL(8'h00)) u_dup (
        .clk(clk), .rst(rst), .key(dup_key), .lut(dup_lut), .wen(wen),
`ifdef MUX_KEY_REG_DEFAULT_EN
        .default_out(dflt),
`endif
        .out(dup_out), .hit(dup_hit), .q(dup_q)
    );

    typedef struct {
        int          inst;     // 0 = u_dec, 1 = u_a, 2 = u_dup
        logic [4:0]  key;
        logic [31:0] exp_out;
        logic        exp_hit;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a register-stage step: set inputs away from the edge, clock once,
    // then compare q of u_a just after the edge.
    task automatic reg_step(input string name, input logic r, input logic w,
                            input logic [2:0] k, input logic [7:0] exp_q);
        @(negedge clk);
        rst   = r;
        wen   = w;
        a_key = k;
        @(posedge clk);
        #1;
        check(name, {24'h0, a_q}, {24'h0, exp_q});
    endtask

    initial begin
        rst      = 1'b1;
        wen      = 1'b0;
        dec_key  = '0;
        a_key    = '0;
        dup_key  = '0;
        dflt     = 8'h3C;
        dec_dflt = 32'hDEAD_BEEF;
        a_lut    = {3'd1, 8'hAA, 3'd2, 8'h55};
        dup_lut  = {3'd4, 8'h11, 3'd4, 8'h22};
        dec_lut  = '0;
        for (int i = 0; i < 32; i++) begin
            dec_lut[DEC_W - 1 - i*37 -: 5]      = 5'(i);
            dec_lut[DEC_W - 1 - i*37 - 5 -: 32] = 32'h1 << i;
        end

        // Combinational vectors with hand-computed expectations.
        vecs.push_back('{0, 5'd3,  32'h0000_0008, 1'b1});
        vecs.push_back('{0, 5'd31, 32'h8000_0000, 1'b1});
        vecs.push_back('{0, 5'd0,  32'h0000_0001, 1'b1});
        vecs.push_back('{0, 5'd17, 32'h0002_0000, 1'b1});
        vecs.push_back('{1, 5'd1,  32'h0000_00AA, 1'b1});
        vecs.push_back('{1, 5'd2,  32'h0000_0055, 1'b1});
        vecs.push_back('{1, 5'd5,  {24'h0, MISS8}, 1'b0});
        vecs.push_back('{1, 5'd0,  {24'h0, MISS8}, 1'b0});
        vecs.push_back('{1, 5'd3,  {24'h0, MISS8}, 1'b0});
        vecs.push_back('{2, 5'd4,  32'h0000_0011, 1'b1});
        vecs.push_back('{2, 5'd0,  {24'h0, MISS8}, 1'b0});

        // Reset edge first, so q is defined before any register checks.
        @(posedge clk);
        #1;
        check("reset_q_a",   {24'h0, a_q}, 32'h7E);
        check("reset_q_dec", dec_q, 32'h0);
        check("reset_q_dup", {24'h0, dup_q}, 32'h0);

        foreach (vecs[n]) begin
            case (vecs[n].inst)
                0:       dec_key = vecs[n].key;
                1:       a_key   = vecs[n].key[2:0];
                default: dup_key = vecs[n].key[2:0];
            endcase
            #1;
            case (vecs[n].inst)
                0: begin
                    check($sformatf("dec_out_k%0d", vecs[n].key), dec_out, vecs[n].exp_out);
                    check($sformatf("dec_hit_k%0d", vecs[n].key), {31'h0, dec_hit}, {31'h0, vecs[n].exp_hit});
                end
                1: begin
                    check($sformatf("a_out_k%0d", vecs[n].key), {24'h0, a_out}, vecs[n].exp_out);
                    check($sformatf("a_hit_k%0d", vecs[n].key), {31'h0, a_hit}, {31'h0, vecs[n].exp_hit});
                end
                default: begin
                    check($sformatf("dup_out_k%0d", vecs[n].key), {24'h0, dup_out}, vecs[n].exp_out);
                    check($sformatf("dup_hit_k%0d", vecs[n].key), {31'h0, dup_hit}, {31'h0, vecs[n].exp_hit});
                end
            endcase
        end

        // Register sequences on u_a.
        reg_step("reg_reset",       1'b1, 1'b0, 3'd0, 8'h7E);
        reg_step("reg_load_aa",     1'b0, 1'b1, 3'd1, 8'hAA);
        reg_step("reg_hold_1",      1'b0, 1'b0, 3'd2, 8'hAA);
        reg_step("reg_hold_2",      1'b0, 1'b0, 3'd5, 8'hAA);
        reg_step("reg_rst_prio",    1'b1, 1'b1, 3'd2, 8'h7E);
        reg_step("reg_reload_aa",   1'b0, 1'b1, 3'd1, 8'hAA);
        reg_step("reg_mid_reset",   1'b1, 1'b0, 3'd1, 8'h7E);
        reg_step("reg_after_rst",   1'b0, 1'b1, 3'd2, 8'h55);
        reg_step("reg_load_miss",   1'b0, 1'b1, 3'd5, MISS8);
        reg_step("reg_load_after",  1'b0, 1'b1, 3'd1, 8'hAA);

        // Changing the key mid-cycle with wen low must not disturb q.
        @(negedge clk);
        wen   = 1'b0;
        a_key = 3'd2;
        #2;
        check("reg_comb_no_effect", {24'h0, a_q}, 32'hAA);
        check("out_follows_key",    {24'h0, a_out}, 32'h55);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
